// File: rtl/hilo_md_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Latency: n/a (types, constants and decode helpers only).
// Backpressure: n/a.
package hilo_md_unit_pkg;

  // Operation codes presented on the op port
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  // One quotient bit per iteration
  localparam int DIV_ITERS = 32;

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/hilo_div_core.sv
// Restoring unsigned divider: one quotient bit per cycle on magnitude operands.
// Latency: load on i_start, DIV_ITERS iteration cycles, o_done high in the last one.
// Backpressure: none; i_flush abandons the divide, i_start reloads at any time.
module hilo_div_core
  import hilo_md_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_done,
  output logic [DATA_W-1:0] o_quot,
  output logic [DATA_W-1:0] o_rem
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_ITERS - 1);

  logic              r_active;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvs;

  logic [DATA_W:0]   w_prem;
  logic [DATA_W:0]   w_trial;
  logic              w_qbit;

  // Shift the next dividend bit into the partial remainder and trial-subtract
  always_comb begin
    w_prem  = {r_rem, r_quo[DATA_W-1]};
    w_trial = w_prem - {1'b0, r_dvs};
    w_qbit  = ~w_trial[DATA_W];
  end

  // Iteration state; a negative trial restores the shifted remainder.
  // The dropped MSB of the kept value is provably zero because the
  // remainder is always below the divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
    end else if (i_flush) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= i_dividend;
      r_dvs    <= i_divisor;
    end else if (r_active) begin
      r_rem <= w_qbit ? w_trial[DATA_W-1:0] : w_prem[DATA_W-1:0];
      r_quo <= {r_quo[DATA_W-2:0], w_qbit};
      if (r_cnt == LAST) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Result registers hold the final values from the cycle after o_done
  always_comb begin
    o_done = r_active && (r_cnt == LAST);
    o_quot = r_quo;
    o_rem  = r_rem;
  end

endmodule

// File: rtl/hilo_md_unit.sv
// EX-stage multiply/divide unit owning HI/LO; MTHI/MTLO write in the accept cycle.
// Latency: mul/div accept at cycle 0, done in 33, HI/LO valid at 34 (fast multiply: done 2, valid 3).
// Backpressure: busy (combinational on start) stalls the front end; flush cancels in-flight work.
// Option: HILO_FAST_MULT_EN selects a registered single-cycle multiply instead of shift-add.
module hilo_md_unit
  import hilo_md_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  mdu_state_e          r_state;
  mdu_state_e          w_next;

  logic                w_accept;
  logic                w_go_mul;
  logic                w_go_div;
  logic                w_rs_neg;
  logic                w_rt_neg;
  logic [DATA_W-1:0]   w_rs_mag;
  logic [DATA_W-1:0]   w_rt_mag;

  logic [DATA_W-1:0]   r_mcand;
  logic [2*DATA_W-1:0] r_acc;
  logic                r_is_div;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic                r_dvz;
  logic [DATA_W-1:0]   r_rs_raw;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  logic                w_div_done;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_fix_hi;
  logic [DATA_W-1:0]   w_fix_lo;

`ifndef HILO_FAST_MULT_EN
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W:0]     w_sum;
`endif

  // Accept qualification and operand magnitudes for the signed ops
  always_comb begin
    w_accept = start && !flush && (r_state == ST_IDLE);
    w_go_mul = w_accept && op_is_mul(op);
    w_go_div = w_accept && op_is_div(op);
    w_rs_neg = op_is_signed(op) && rs_data[DATA_W-1];
    w_rt_neg = op_is_signed(op) && rt_data[DATA_W-1];
    w_rs_mag = w_rs_neg ? (~rs_data + DATA_W'(1)) : rs_data;
    w_rt_mag = w_rt_neg ? (~rt_data + DATA_W'(1)) : rt_data;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state; flush wins in every state
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_go_mul)      w_next = ST_MUL;
          else if (w_go_div) w_next = ST_DIV;
        end
`ifdef HILO_FAST_MULT_EN
        ST_MUL:  w_next = ST_FIX;
`else
        ST_MUL:  if (r_cnt == MUL_LAST) w_next = ST_FIX;
`endif
        ST_DIV:  if (w_div_done) w_next = ST_FIX;
        ST_FIX:  w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; busy rises in the accept cycle so a dependent MFHI/MFLO stalls at once
  always_comb begin
    busy = (r_state != ST_IDLE) || w_go_mul || w_go_div;
    done = (r_state == ST_FIX) && !flush;
  end

`ifndef HILO_FAST_MULT_EN
  // Shift-add step: conditionally add the multiplicand into the upper half
  always_comb begin
    w_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} +
            (r_acc[0] ? {1'b0, r_mcand} : {(DATA_W+1){1'b0}});
  end
`endif

  // Multiply datapath; the multiplier magnitude starts in the low half of the accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
`ifndef HILO_FAST_MULT_EN
      r_cnt   <= '0;
`endif
    end else if (flush) begin
`ifndef HILO_FAST_MULT_EN
      r_cnt   <= '0;
`endif
    end else if (w_go_mul) begin
      r_mcand <= w_rs_mag;
      r_acc   <= {{DATA_W{1'b0}}, w_rt_mag};
`ifndef HILO_FAST_MULT_EN
      r_cnt   <= '0;
`endif
    end else if (r_state == ST_MUL) begin
`ifdef HILO_FAST_MULT_EN
      r_acc <= {{DATA_W{1'b0}}, r_mcand} * {{DATA_W{1'b0}}, r_acc[DATA_W-1:0]};
`else
      r_acc <= {w_sum, r_acc[DATA_W-1:1]};
      r_cnt <= (r_cnt == MUL_LAST) ? '0 : r_cnt + CNT_W'(1);
`endif
    end
  end

  // Capture sign-fix and divide-by-zero context at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dvz     <= 1'b0;
      r_rs_raw  <= '0;
    end else if (w_go_mul || w_go_div) begin
      r_is_div  <= w_go_div;
      r_neg_res <= w_rs_neg ^ w_rt_neg;
      r_neg_rem <= w_rs_neg && w_go_div;
      r_dvz     <= w_go_div && (rt_data == '0);
      r_rs_raw  <= rs_data;
    end
  end

  hilo_div_core #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_go_div),
    .i_flush    (flush),
    .i_dividend (w_rs_mag),
    .i_divisor  (w_rt_mag),
    .o_done     (w_div_done),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  // Sign correction applied in FIX; divide-by-zero bypasses it entirely
  always_comb begin
    w_prod   = r_neg_res ? (~r_acc + (2*DATA_W)'(1)) : r_acc;
    w_fix_hi = w_prod[2*DATA_W-1:DATA_W];
    w_fix_lo = w_prod[DATA_W-1:0];
    if (r_is_div) begin
      if (r_dvz) begin
        w_fix_hi = r_rs_raw;
        w_fix_lo = '1;
      end else begin
        w_fix_lo = r_neg_res ? (~w_quot + DATA_W'(1)) : w_quot;
        w_fix_hi = r_neg_rem ? (~w_rem + DATA_W'(1)) : w_rem;
      end
    end
  end

  // HI/LO: result write in FIX unless flushed, MTHI/MTLO in their accept cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == ST_FIX) && !flush) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end else if (w_accept && (op == MDU_MTHI)) begin
      r_hi <= rs_data;
    end else if (w_accept && (op == MDU_MTLO)) begin
      r_lo <= rs_data;
    end
  end

  // Architectural HI/LO outputs
  always_comb begin
    hi = r_hi;
    lo = r_lo;
  end

endmodule
